// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants.
package core_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Low address bits that must be zero for an instruction address.
  localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;
  localparam int unsigned PC_STEP          = 4;

endpackage

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, keeps one imem request in flight,
// and presents fetched instructions to decode over a valid/ready handshake.
module fetch_pc_unit
  import core_pkg::*;
#(
  parameter int unsigned          WordSize    = 32,
  parameter logic [WordSize-1:0]  ResetVector = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_taken,
  input  logic [WordSize-1:0] branch_addr,
  output logic                imem_req,
  output logic [WordSize-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [WordSize-1:0] imem_rdata,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [WordSize-1:0] if_pc,
  output logic [WordSize-1:0] if_instr
);

  // Handshakes: imem request is accepted on a cycle with imem_req && imem_gnt
  // (unless a redirect arrives that cycle); an instruction is consumed on a
  // cycle with if_valid && if_ready, and a redirect overrides both.
  localparam logic [WordSize-1:0] AlignClear = ~{{(WordSize-2){1'b0}}, INSTR_ALIGN_MASK};
  localparam logic [WordSize-1:0] Step       = WordSize'(PC_STEP);

  fetch_state_t        state, state_next;
  logic [WordSize-1:0] pc, req_pc;
  logic                kill;
  logic                grant;
  logic                accept_rsp;

  assign grant      = (state == REQ) && imem_gnt && !branch_taken;
  assign accept_rsp = (state == WAIT) && imem_rvalid && !kill && !branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= REQ;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      REQ:  if (grant) state_next = WAIT;
      WAIT: if (imem_rvalid) state_next = accept_rsp ? HOLD : REQ;
      HOLD: if (branch_taken || if_ready) state_next = REQ;
      default: state_next = REQ;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (state == REQ && !rst) imem_req = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= ResetVector & AlignClear;
      req_pc   <= '0;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      if (branch_taken) pc <= branch_addr & AlignClear;
      else if (grant)   pc <= pc + Step;

      if (grant) req_pc <= pc;

      // A redirect while waiting poisons the response still owed by memory.
      if (state == WAIT) begin
        if (imem_rvalid)       kill <= 1'b0;
        else if (branch_taken) kill <= 1'b1;
      end

      if (accept_rsp) begin
        if_valid <= 1'b1;
        if_pc    <= req_pc;
        if_instr <= imem_rdata;
      end else if (state == HOLD && (branch_taken || if_ready)) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end: owns the architectural PC and issues one instruction-memory request at a time.
- Consumes the redirect produced by the branch address stage (branch_taken, branch_addr).
- Presents fetched instructions to decode through a valid/ready handshake.
- Sits between the branch address stage (feedback path) and the IF/ID boundary.

Parameters:
- WordSize, 32, width of PC, addresses and instruction data.
- ResetVector, 0, PC value loaded on reset; low 2 bits are ignored.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- branch_taken  input  1  single-cycle redirect request from the branch address stage.
- branch_addr  input  WordSize  redirect target; bits [1:0] are forced to 0.
- imem_req  output  1  request valid to instruction memory.
- imem_addr  output  WordSize  request address; always word aligned.
- imem_gnt  input  1  memory accepts the request this cycle when imem_req=1.
- imem_rvalid  input  1  response valid; at most one per granted request, at least 1 cycle after grant.
- imem_rdata  input  WordSize  response instruction word.
- if_valid  output  1  if_pc and if_instr hold a valid instruction.
- if_ready  input  1  decode accepts the instruction when if_valid=1.
- if_pc  output  WordSize  PC of the presented instruction.
- if_instr  output  WordSize  presented instruction word.

Behaviour:
- Reset (async, while rst=1):
  - state=REQ, pc=ResetVector with bits [1:0]=0, kill=0.
  - imem_req=0 while rst is asserted; if_valid=0, if_pc=0, if_instr=0.
  - imem_req rises in the first cycle after rst deasserts.
- States:
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt, record req_pc=pc, set pc=pc+4, and go to WAIT.
  - WAIT: imem_req=0; waiting for imem_rvalid.
    - If rvalid and kill=0: latch if_pc=req_pc and if_instr=imem_rdata, set if_valid=1, go to HOLD.
    - If rvalid and kill=1: discard the response, clear kill, go to REQ.
  - HOLD: if_valid=1 and outputs stay stable. On if_ready, clear if_valid and go to REQ next cycle.
- Latency: grant-to-if_valid is rvalid latency + 1 cycle. Exactly one request is outstanding; the next request issues the cycle after acceptance.
- Redirect (branch_taken=1) has priority over all other events in the same cycle:
  - REQ: pc=branch_addr. No grant is recorded even if imem_gnt=1 (memory must drop an ungated grant; imem_req is held for the new address next cycle). State stays REQ.
  - WAIT: pc=branch_addr, kill=1. If rvalid arrives in the same cycle, drop it, clear kill, go to REQ.
  - HOLD: drop the held instruction (if_valid=0 next cycle, even if if_ready=1), pc=branch_addr, go to REQ.
- PC arithmetic: pc+4 is modulo 2^WordSize; 0xFFFFFFFC wraps to 0x00000000 with no flag.
- imem_addr, if_pc and pc are never misaligned.
- Decode must treat if_valid as a pulse-free level and not sample it while it is 0.
- Reset asserted mid-transaction abandons any in-flight request. The memory is reset by the same rst.
- No outputs are X after reset. if_instr holds its last value when if_valid=0.

Decomposition:
- Shared package core_pkg holds:
  - fetch_state_t enum {REQ, WAIT, HOLD}.
  - INSTR_ALIGN_MASK constant.
  - PC_STEP=4 constant.
- Single module with no sub-module. PC next-value selection stays inline, being one priority mux.

Test Plan:
- Reset, then rst=0 with gnt tied 1 and rvalid 1 cycle later, if_ready=1 → imem_addr sequence 0x0, 0x4, 0x8. if_pc matches each, if_valid one cycle after each rvalid.
- Grant at 0x8 with if_ready=0 for 5 cycles → if_valid stays 1, if_pc=0x8, if_instr stable, imem_req=0 throughout. Release ready → request 0xC next cycle.
- branch_taken with branch_addr=0x103 while in WAIT, and rvalid 2 cycles later → response discarded, no if_valid. Next imem_addr=0x100.
- branch_taken and imem_rvalid in the same cycle, and branch_taken in HOLD with if_ready=1 → both instructions dropped. imem_addr=target next cycle.
- ResetVector=0xFFFFFFF8, two fetches → addresses 0xFFFFFFF8, 0xFFFFFFFC, then 0x00000000.
- Assert rst while in WAIT, and deliver rvalid after release → if_valid=0 at once. Stale rvalid ignored only if it lands in REQ (checker: no if_valid without a grant), and fetch restarts at ResetVector.
